// File: rtl/mainfsm_ws_if.sv
// mainfsm_ws_if
// Bundles the signals between the multicycle control FSM and the rest of the
// controller, datapath, memory port and multiplier.
//   Decoder inputs : Op, Funct, IsMul
//   Completion     : MemReady (memory), MulDone (multiplier)
//   Datapath ctrl  : IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
//                    RegW, MemW, Branch, ALUOp
//   Memory/mul     : MemReq, MulStart
//   Status         : Fault, StateOut
// The master modport is the FSM, and the slave modport is everything around it.
interface mainfsm_ws_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IsMul;
    logic       MemReady;
    logic       MulDone;

    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       MemReq;
    logic       MulStart;
    logic       Fault;
    logic [3:0] StateOut;

    modport master (
        input  Op, Funct, IsMul, MemReady, MulDone,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW,
               MemW, Branch, ALUOp, MemReq, MulStart, Fault, StateOut
    );

    modport slave (
        output Op, Funct, IsMul, MemReady, MulDone,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW,
               MemW, Branch, ALUOp, MemReq, MulStart, Fault, StateOut
    );
endinterface

// File: rtl/mainfsm_ws.sv
// mainfsm_ws
// Multicycle ARMv4 main control FSM with wait states. Fetch, load and store
// issue a memory request and wait for MemReady. Multiplies can optionally
// run through an iterative multiplier (MUL_EN). A watchdog counts consecutive
// wait cycles and traps a stalled access, or an undefined Op, into a sticky
// FAULT state that only reset leaves.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mainfsm_ws_if.master (decoder inputs, completion flags, controls)
// Parameters:
//   MUL_EN   1 = IsMul selects the multiply path, 0 = IsMul ignored
//   TO_W     watchdog counter width
//   TIMEOUT  maximum consecutive wait cycles before FAULT (1..2**TO_W-1)
module mainfsm_ws #(
    parameter bit MUL_EN  = 1'b1,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input logic         clk,
    input logic         reset,
    mainfsm_ws_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        MULST    = 4'd10,
        MULWAIT  = 4'd11,
        MULWB    = 4'd12,
        FAULT    = 4'd15
    } state_t;

    // The field order matches the order used in the control-word table below.
    typedef struct packed {
        logic       next_pc;
        logic       branch;
        logic       mem_w;
        logic       reg_w;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
    } ctrl_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t          state, state_next;
    logic [TO_W-1:0] wd, wd_next;
    logic            wait_st;    // the current state waits on a completion flag
    logic            done;       // that completion flag
    ctrl_t           ctrl;

    // Only I (bit 5) and L (bit 0) steer the sequence.
    logic unused_funct;
    assign unused_funct = ^bus.Funct[4:1];

    // NOTE: sequential state uses non-blocking assignments only, and reset is
    // sampled on the clock edge because this block resets synchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            wd    <= '0;
        end else begin
            state <= state_next;
            wd    <= wd_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_next = state;
        wait_st    = 1'b0;
        done       = 1'b0;
        wd_next    = '0;

        unique case (state)
            FETCH: begin
                wait_st = 1'b1;
                done    = bus.MemReady;
                if (done) state_next = DECODE;
            end
            DECODE: begin
                unique case (bus.Op)
                    2'b00: begin
                        if (MUL_EN && bus.IsMul) state_next = MULST;
                        else if (bus.Funct[5])   state_next = EXECUTEI;
                        else                     state_next = EXECUTER;
                    end
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FAULT;
                endcase
            end
            MEMADR:   state_next = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD: begin
                wait_st = 1'b1;
                done    = bus.MemReady;
                if (done) state_next = MEMWB;
            end
            MEMWB:    state_next = FETCH;
            MEMWR: begin
                wait_st = 1'b1;
                done    = bus.MemReady;
                if (done) state_next = FETCH;
            end
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            MULST:    state_next = MULWAIT;
            MULWAIT: begin
                wait_st = 1'b1;
                done    = bus.MulDone;
                if (done) state_next = MULWB;
            end
            MULWB:    state_next = FETCH;
            FAULT:    state_next = FAULT;
            default:  state_next = FAULT;   // unused encodings are treated as a trap
        endcase

        // The count survives only while a wait state keeps stalling. Because
        // completion is tested first, a completion exactly at TIMEOUT wins.
        if (wait_st && !done) begin
            if (wd == TO_LIM) state_next = FAULT;
            else              wd_next    = wd + 1'b1;
        end
    end

    // Control word {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
    always_comb begin
        ctrl = '0;
        unique case (state)
            // PC and IR update once, on the cycle the fetch completes.
            FETCH:    ctrl = {bus.MemReady, 3'b000, bus.MemReady, 1'b0,
                              2'b10, 2'b00, 2'b10, 1'b0};
            DECODE:   ctrl = 13'b0000001001100;
            EXECUTER: ctrl = 13'b0000000001001;
            EXECUTEI: ctrl = 13'b0000000001011;
            ALUWB:    ctrl = 13'b0001000000000;
            MEMADR:   ctrl = 13'b0000010001010;
            MEMRD:    ctrl = 13'b0000010000000;
            MEMWB:    ctrl = 13'b0001000100000;
            MEMWR:    ctrl = 13'b0010010000000;
            BRANCH:   ctrl = 13'b1100000000010;
            MULWB:    ctrl = 13'b0001001100000;
            default:  ctrl = '0;
        endcase
    end

    // Side-effecting enables are masked during reset so that an access
    // in flight is dropped in the same cycle.
    assign bus.NextPC    = ctrl.next_pc  & ~reset;
    assign bus.IRWrite   = ctrl.ir_write & ~reset;
    assign bus.RegW      = ctrl.reg_w    & ~reset;
    assign bus.MemW      = ctrl.mem_w    & ~reset;
    assign bus.MemReq    = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) & ~reset;
    assign bus.MulStart  = (state == MULST) & ~reset;
    assign bus.Branch    = ctrl.branch;
    assign bus.AdrSrc    = ctrl.adr_src;
    assign bus.ResultSrc = ctrl.result_src;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.Fault     = (state == FAULT);
    assign bus.StateOut  = state;

endmodule

// File: tb/tb_mainfsm_ws.sv
// tb_mainfsm_ws
// Self-checking bench for mainfsm_ws. Two instances share clock, reset and
// inputs: dut1 has MUL_EN=1 and dut0 has MUL_EN=0. The stimulus has three parts:
// a decode routing table, hand-written wait-state, watchdog and reset
// sequences, and random instructions. For each random instruction the bench
// builds the expected per-cycle state trace and compares it against the
// control-word table.
module tb_mainfsm_ws;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;
    logic       is_mul = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mul_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mainfsm_ws_if bus1 ();
    mainfsm_ws_if bus0 ();

    assign bus1.Op = op;        assign bus0.Op = op;
    assign bus1.Funct = funct;  assign bus0.Funct = funct;
    assign bus1.IsMul = is_mul; assign bus0.IsMul = is_mul;
    assign bus1.MemReady = mem_ready; assign bus0.MemReady = mem_ready;
    assign bus1.MulDone = mul_done;   assign bus0.MulDone = mul_done;

    mainfsm_ws #(.MUL_EN(1'b1), .TO_W(4), .TIMEOUT(15)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    mainfsm_ws #(.MUL_EN(1'b0), .TO_W(4), .TIMEOUT(15)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,MemReq,MulStart,Fault}
    function automatic logic [15:0] act_vec1();
        return {bus1.NextPC, bus1.Branch, bus1.MemW, bus1.RegW, bus1.IRWrite,
                bus1.AdrSrc, bus1.ResultSrc, bus1.ALUSrcA, bus1.ALUSrcB,
                bus1.ALUOp, bus1.MemReq, bus1.MulStart, bus1.Fault};
    endfunction

    // Expected outputs for a state code, taken from the control-word table.
    function automatic logic [15:0] exp_vec(input int s, input bit mr);
        logic [12:0] c;
        case (s)
            0:       c = {mr, 3'b000, mr, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0};
            1:       c = 13'b0000001001100;
            2:       c = 13'b0000010001010;
            3:       c = 13'b0000010000000;
            4:       c = 13'b0001000100000;
            5:       c = 13'b0010010000000;
            6:       c = 13'b0000000001001;
            7:       c = 13'b0000000001011;
            8:       c = 13'b0001000000000;
            9:       c = 13'b1100000000010;
            12:      c = 13'b0001001100000;
            default: c = '0;
        endcase
        return {c, (s == 0 || s == 3 || s == 5), (s == 10), (s == 15)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle. The gated enables must be low while reset is high.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        mul_done = 1'b0;
        @(negedge clk);
        check("enables low during reset",
              {bus1.MemReq, bus1.MemW, bus1.RegW, bus1.NextPC, bus1.IRWrite, bus1.MulStart}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Expected per-cycle trace: state code plus the MemReady/MulDone to drive.
    int st_q[$];
    bit mr_q[$];
    bit md_q[$];

    function automatic void push(input int s, input bit mr, input bit md);
        st_q.push_back(s);
        mr_q.push_back(mr);
        md_q.push_back(md);
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one instruction on dut1, starting in FETCH. Checks every cycle and
    // returns pulse counts over the instruction.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic im,
                             input int wf, input int wdat, input int wm,
                             output int cycles, output int n_npc, output int n_regw,
                             output int n_irw, output int n_memw, output int n_mulst,
                             output int n_mulst0);
        st_q.delete(); mr_q.delete(); md_q.delete();
        for (int i = 0; i < wf; i++) push(0, 1'b0, rb());
        push(0, 1'b1, rb());
        push(1, rb(), rb());
        case (o)
            2'b00: begin
                if (im) begin
                    push(10, rb(), rb());
                    for (int i = 0; i < wm; i++) push(11, rb(), 1'b0);
                    push(11, rb(), 1'b1);
                    push(12, rb(), rb());
                end else begin
                    push(f[5] ? 7 : 6, rb(), rb());
                    push(8, rb(), rb());
                end
            end
            2'b01: begin
                push(2, rb(), rb());
                if (f[0]) begin
                    for (int i = 0; i < wdat; i++) push(3, 1'b0, rb());
                    push(3, 1'b1, rb());
                    push(4, rb(), rb());
                end else begin
                    for (int i = 0; i < wdat; i++) push(5, 1'b0, rb());
                    push(5, 1'b1, rb());
                end
            end
            default: push(9, rb(), rb());
        endcase

        op = o; funct = f; is_mul = im;
        n_npc = 0; n_regw = 0; n_irw = 0; n_memw = 0; n_mulst = 0; n_mulst0 = 0;
        cycles = st_q.size();
        for (int i = 0; i < st_q.size(); i++) begin
            mem_ready = mr_q[i];
            mul_done = md_q[i];
            @(negedge clk);
            check($sformatf("state cyc%0d", i), bus1.StateOut, st_q[i]);
            check($sformatf("outputs st%0d", st_q[i]), act_vec1(), exp_vec(st_q[i], mr_q[i]));
            n_npc += int'(bus1.NextPC);
            n_regw += int'(bus1.RegW);
            n_irw += int'(bus1.IRWrite);
            n_memw += int'(bus1.MemW);
            n_mulst += int'(bus1.MulStart);
            n_mulst0 += int'(bus0.MulStart);
            step();
        end
        check("back to FETCH", bus1.StateOut, 0);
    endtask

    // Holds MemReady low and counts FETCH cycles until FAULT (bounded).
    task automatic stall_to_fault(input string tag);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus1.StateOut == 4'd15) begin
                hit = 1'b1;
                break;
            end
            if (bus1.StateOut == 4'd0) n++;
            step();
        end
        check({tag, " reached FAULT"}, 32'(hit), 1);
        check({tag, " stall cycles"}, n, 16);
        check({tag, " fault outputs"}, act_vec1(), 16'h0001);
        mem_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check({tag, " fault sticky"}, bus1.StateOut, 15);
        check({tag, " Fault flag"}, bus1.Fault, 1);
        step();
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic       ismul;
        logic [3:0] exp1;   // state after DECODE, MUL_EN=1
        logic [3:0] exp0;   // state after DECODE, MUL_EN=0
    } dec_vec_t;

    initial begin
        dec_vec_t dec_tab[8];
        int cyc, npc, regw, irw, memw, mulst, mulst0;

        dec_tab[0] = '{2'b00, 6'b001000, 1'b0, 4'd6,  4'd6};
        dec_tab[1] = '{2'b00, 6'b101000, 1'b0, 4'd7,  4'd7};
        dec_tab[2] = '{2'b00, 6'b000000, 1'b1, 4'd10, 4'd6};
        dec_tab[3] = '{2'b00, 6'b100000, 1'b1, 4'd10, 4'd7};
        dec_tab[4] = '{2'b01, 6'b011001, 1'b0, 4'd2,  4'd2};
        dec_tab[5] = '{2'b01, 6'b011000, 1'b0, 4'd2,  4'd2};
        dec_tab[6] = '{2'b10, 6'b100000, 1'b0, 4'd9,  4'd9};
        dec_tab[7] = '{2'b11, 6'b000000, 1'b0, 4'd15, 4'd15};

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset state", bus1.StateOut, 0);
        check("reset outputs", act_vec1(), exp_vec(0, 1'b0));

        // Decode routing table
        for (int v = 0; v < 8; v++) begin
            do_reset();
            op = dec_tab[v].op; funct = dec_tab[v].funct; is_mul = dec_tab[v].ismul;
            mem_ready = 1'b1;
            step();
            @(negedge clk);
            check($sformatf("vec%0d DECODE", v), bus1.StateOut, 1);
            check($sformatf("vec%0d DECODE outputs", v), act_vec1(), exp_vec(1, 1'b1));
            step();
            @(negedge clk);
            check($sformatf("vec%0d route MUL_EN=1", v), bus1.StateOut, dec_tab[v].exp1);
            check($sformatf("vec%0d route MUL_EN=0", v), bus0.StateOut, dec_tab[v].exp0);
            step();
        end

        // Zero-wait ADD reg
        do_reset();
        run_instr(2'b00, 6'b001000, 1'b0, 0, 0, 0, cyc, npc, regw, irw, memw, mulst, mulst0);
        check("ADD cycles", cyc, 4);
        check("ADD NextPC pulses", npc, 1);
        check("ADD RegW pulses", regw, 1);

        // LDR, 3 fetch waits and 2 data waits
        run_instr(2'b01, 6'b011001, 1'b0, 3, 2, 0, cyc, npc, regw, irw, memw, mulst, mulst0);
        check("LDR cycles", cyc, 10);
        check("LDR NextPC pulses", npc, 1);
        check("LDR IRWrite pulses", irw, 1);
        check("LDR RegW pulses", regw, 1);

        // STR, 5 data waits
        run_instr(2'b01, 6'b011000, 1'b0, 0, 5, 0, cyc, npc, regw, irw, memw, mulst, mulst0);
        check("STR MemW cycles", memw, 6);
        check("STR cycles", cyc, 9);

        // MUL, both MUL_EN settings see the same inputs
        do_reset();
        run_instr(2'b00, 6'b000000, 1'b1, 0, 0, 3, cyc, npc, regw, irw, memw, mulst, mulst0);
        check("MUL MulStart pulses", mulst, 1);
        check("MUL RegW pulses", regw, 1);
        check("MUL cycles", cyc, 8);
        check("MUL_EN=0 MulStart pulses", mulst0, 0);

        // Watchdog expiry in FETCH
        do_reset();
        stall_to_fault("fetch stall");

        // Completion exactly at the limit wins
        do_reset();
        mem_ready = 1'b0;
        repeat (15) step();
        mem_ready = 1'b1;
        @(negedge clk);
        check("limit FETCH ready NextPC", bus1.NextPC, 1);
        step();
        @(negedge clk);
        check("limit -> DECODE", bus1.StateOut, 1);
        check("limit no Fault", bus1.Fault, 0);
        step();

        // Reset in the middle of a stalled store
        do_reset();
        op = 2'b01; funct = 6'b011000; is_mul = 1'b0;
        mem_ready = 1'b1;
        step(); step();
        mem_ready = 1'b0;
        step(); step(); step();
        @(negedge clk);
        check("MEMWR stalled", bus1.StateOut, 5);
        check("MEMWR MemW held", bus1.MemW, 1);
        reset = 1'b1;
        #1;
        check("reset masks MemW", bus1.MemW, 0);
        check("reset masks MemReq", bus1.MemReq, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("after reset state", bus1.StateOut, 0);
        check("after reset MemW", bus1.MemW, 0);
        check("after reset Fault", bus1.Fault, 0);
        step();
        do_reset();
        stall_to_fault("watchdog cleared");

        // Random instructions
        do_reset();
        for (int k = 0; k < 40; k++) begin
            logic [1:0] ro;
            logic [5:0] rf;
            logic       rm;
            ro = 2'($urandom_range(0, 2));
            rf = 6'($urandom);
            rm = (ro == 2'b00) && ($urandom_range(0, 3) == 0);
            run_instr(ro, rf, rm, $urandom_range(0, 5), $urandom_range(0, 5),
                      $urandom_range(0, 5), cyc, npc, regw, irw, memw, mulst, mulst0);
            check($sformatf("rand%0d NextPC pulses", k), npc, (ro == 2'b10) ? 2 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
